key_press_pulse: RTL and testbench

//  Consumer end of the 2-flop input synchronizer. Takes one synchronized, active-high button level.

---
 rtl/key_press_pulse_if.sv | 30 +++
 rtl/key_press_pulse.sv | 145 ++++++++++++++
 tb/tb_key_press_pulse.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_press_pulse_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_press_pulse_if
//  Purpose  : Button level in, debounced event pulses and held level out.
//  Revision : 1.0  initial release
// ============================================================================
interface key_press_pulse_if;
    logic key_sync;
    logic press;
    logic rpt;
    logic release_pulse;
    logic held;

    modport master (
        output key_sync,
        input  press,
        input  rpt,
        input  release_pulse,
        input  held
    );

    modport slave (
        input  key_sync,
        output press,
        output rpt,
        output release_pulse,
        output held
    );
endinterface
`default_nettype wire

// File: rtl/key_press_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : key_press_pulse
//  Purpose  : Debounces one synchronized button level into press / auto-repeat
//             / release pulses plus a debounced held level.
//  Revision : 1.0  initial release
// ============================================================================
module key_press_pulse #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic               clk,
    input  logic               reset,
    key_press_pulse_if.slave   kp
);

    localparam int               c_DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DW-1:0]  c_DLAST = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DW-1:0]  c_DONE  = c_DW'(1);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_DB_PRESS   = 2'd1;
    localparam logic [1:0] c_PRESSED    = 2'd2;
    localparam logic [1:0] c_DB_RELEASE = 2'd3;

    logic            w_key;
    logic [1:0]      r_state;
    logic [c_DW-1:0] r_dcnt;
    logic            r_press;
    logic            r_release;
    logic            r_held;
    logic            w_rpt;

    assign w_key = kp.key_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_dcnt    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_key) begin
                        r_state <= c_DB_PRESS;
                        r_dcnt  <= c_DONE;
                    end
                end
                c_DB_PRESS: begin
                    if (!w_key) begin
                        r_state <= c_IDLE;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == c_DLAST) begin
                        r_state <= c_PRESSED;
                        r_dcnt  <= '0;
                        r_press <= 1'b1;
                        r_held  <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + c_DONE;
                    end
                end
                c_PRESSED: begin
                    if (!w_key) begin
                        r_state <= c_DB_RELEASE;
                        r_dcnt  <= c_DONE;
                    end
                end
                c_DB_RELEASE: begin
                    if (w_key) begin
                        r_state <= c_PRESSED;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == c_DLAST) begin
                        r_state   <= c_IDLE;
                        r_dcnt    <= '0;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_dcnt  <= '0;
                end
            endcase
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rpt
            localparam int c_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int c_RW   = $clog2(c_RMAX + 1);
            localparam logic [c_RW-1:0] c_DTGT = c_RW'(REPEAT_DELAY - 1);
            localparam logic [c_RW-1:0] c_PTGT = c_RW'(REPEAT_PERIOD - 1);
            localparam logic [c_RW-1:0] c_RONE = c_RW'(1);

            logic [c_RW-1:0] r_rcnt;
            logic            r_first;
            logic            r_rpt;
            logic [c_RW-1:0] w_target;

            // First repeat waits the long delay, later ones the period.
            assign w_target = r_first ? c_DTGT : c_PTGT;
            assign w_rpt    = r_rpt;

            // Timer only advances in PRESSED with key=1, so it freezes during release debounce.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rcnt  <= '0;
                    r_first <= 1'b1;
                    r_rpt   <= 1'b0;
                end else begin
                    r_rpt <= 1'b0;
                    if (r_state == c_DB_PRESS && w_key && r_dcnt == c_DLAST) begin
                        r_rcnt  <= '0;
                        r_first <= 1'b1;
                    end else if (r_state == c_PRESSED && w_key) begin
                        if (r_rcnt == w_target) begin
                            r_rpt   <= 1'b1;
                            r_rcnt  <= '0;
                            r_first <= 1'b0;
                        end else begin
                            r_rcnt <= r_rcnt + c_RONE;
                        end
                    end
                end
            end
        end else begin : g_no_rpt
            assign w_rpt = 1'b0;
        end
    endgenerate

    assign kp.press         = r_press;
    assign kp.rpt           = w_rpt;
    assign kp.release_pulse = r_release;
    assign kp.held          = r_held;

endmodule
`default_nettype wire

// File: tb/tb_key_press_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_press_pulse
//  Purpose  : Directed self-checking bench for key_press_pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_press_pulse;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    key_press_pulse_if kp ();
    key_press_pulse_if kp_nr ();

    key_press_pulse #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp.slave)
    );

    key_press_pulse #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
    ) dut_nr (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_nr.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle(input int n);
        kp.key_sync = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        kp.key_sync    = 1'b1;
        kp_nr.key_sync = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({kp.press, kp.rpt, kp.release_pulse, kp.held} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {kp.press, kp.rpt, kp.release_pulse, kp.held});
        end
        n_checks++;
        if ({kp_nr.press, kp_nr.rpt, kp_nr.release_pulse, kp_nr.held} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outputs_nr: got %b expected 0000", {kp_nr.press, kp_nr.rpt, kp_nr.release_pulse, kp_nr.held});
        end
        kp.key_sync    = 1'b0;
        kp_nr.key_sync = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 8; i++) begin
            kp.key_sync = (i < 3);
            tick();
            n_checks++;
            if ({kp.press, kp.held, kp.rpt} !== 3'b000) begin
                n_errors++;
                $display("FAIL glitch step %0d: press/held/rpt got %b expected 000", i, {kp.press, kp.held, kp.rpt});
            end
        end
    endtask

    task automatic test_clean_press();
        logic exp_p, exp_h, exp_r;
        kp.key_sync = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_p = (i == 3);
            exp_h = (i >= 3);
            n_checks++;
            if ({kp.press, kp.held, kp.rpt} !== {exp_p, exp_h, 1'b0}) begin
                n_errors++;
                $display("FAIL clean_press step %0d: press/held/rpt got %b expected %b",
                         i, {kp.press, kp.held, kp.rpt}, {exp_p, exp_h, 1'b0});
            end
        end
        kp.key_sync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_r = (i == 3);
            exp_h = (i < 3);
            n_checks++;
            if ({kp.release_pulse, kp.held, kp.press} !== {exp_r, exp_h, 1'b0}) begin
                n_errors++;
                $display("FAIL clean_release step %0d: release/held/press got %b expected %b",
                         i, {kp.release_pulse, kp.held, kp.press}, {exp_r, exp_h, 1'b0});
            end
        end
    endtask

    task automatic test_release_bounce();
        kp.key_sync = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (kp.held !== 1'b1) begin
            n_errors++;
            $display("FAIL bounce_setup_held: got %b expected 1", kp.held);
        end
        for (int i = 0; i < 8; i++) begin
            kp.key_sync = !(i < 2);
            tick();
            n_checks++;
            if ({kp.held, kp.release_pulse, kp.press} !== 3'b100) begin
                n_errors++;
                $display("FAIL release_bounce step %0d: held/release/press got %b expected 100",
                         i, {kp.held, kp.release_pulse, kp.press});
            end
        end
        drive_idle(6);
        n_checks++;
        if (kp.held !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_final_held: got %b expected 0", kp.held);
        end
    endtask

    task automatic test_auto_repeat();
        int   pulses;
        logic exp_r;
        pulses = 0;
        kp.key_sync = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (kp.press !== 1'b1) begin
            n_errors++;
            $display("FAIL repeat_press: got %b expected 1", kp.press);
        end
        for (int k = 1; k <= 45; k++) begin
            tick();
            exp_r = (k == 16) || (k == 24) || (k == 32) || (k == 40);
            if (kp.rpt === 1'b1) pulses++;
            n_checks++;
            if ({kp.rpt, kp.press} !== {exp_r, 1'b0}) begin
                n_errors++;
                $display("FAIL auto_repeat c0+%0d: rpt/press got %b expected %b", k, {kp.rpt, kp.press}, {exp_r, 1'b0});
            end
        end
        n_checks++;
        if (pulses !== 4) begin
            n_errors++;
            $display("FAIL repeat_count: got %0d expected 4", pulses);
        end
        drive_idle(6);
    endtask

    task automatic test_rpt_suppress();
        kp.key_sync = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int k = 1; k <= 15; k++) tick();
        // Key drops exactly on the edge where the first repeat was due.
        kp.key_sync = 1'b0;
        tick();
        n_checks++;
        if ({kp.rpt, kp.held} !== 2'b01) begin
            n_errors++;
            $display("FAIL suppress_drop: rpt/held got %b expected 01", {kp.rpt, kp.held});
        end
        kp.key_sync = 1'b1;
        tick();
        n_checks++;
        if (kp.rpt !== 1'b0) begin
            n_errors++;
            $display("FAIL suppress_resume: rpt got %b expected 0", kp.rpt);
        end
        tick();
        n_checks++;
        if (kp.rpt !== 1'b1) begin
            n_errors++;
            $display("FAIL suppress_deferred_rpt: rpt got %b expected 1", kp.rpt);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (kp.rpt !== (k == 8)) begin
                n_errors++;
                $display("FAIL suppress_period +%0d: rpt got %b expected %b", k, kp.rpt, (k == 8));
            end
        end
        drive_idle(6);
    endtask

    task automatic test_reset_mid_hold();
        kp.key_sync = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (kp.held !== 1'b1) begin
            n_errors++;
            $display("FAIL midhold_setup_held: got %b expected 1", kp.held);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({kp.press, kp.rpt, kp.release_pulse, kp.held} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midhold_reset: got %b expected 0000", {kp.press, kp.rpt, kp.release_pulse, kp.held});
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if ({kp.press, kp.held} !== {1'(k == 4), 1'(k >= 4)}) begin
                n_errors++;
                $display("FAIL post_reset_press +%0d: press/held got %b expected %b",
                         k, {kp.press, kp.held}, {1'(k == 4), 1'(k >= 4)});
            end
        end
        drive_idle(6);
    endtask

    task automatic test_repeat_disabled();
        int presses;
        int rpts;
        presses = 0;
        rpts    = 0;
        kp_nr.key_sync = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (kp_nr.press === 1'b1) presses++;
            if (kp_nr.rpt !== 1'b0) rpts++;
        end
        n_checks++;
        if (presses !== 1) begin
            n_errors++;
            $display("FAIL nr_press_count: got %0d expected 1", presses);
        end
        n_checks++;
        if (rpts !== 0) begin
            n_errors++;
            $display("FAIL nr_rpt_cycles: got %0d expected 0", rpts);
        end
        n_checks++;
        if (kp_nr.held !== 1'b1) begin
            n_errors++;
            $display("FAIL nr_held: got %b expected 1", kp_nr.held);
        end
        kp_nr.key_sync = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        reset          = 1'b1;
        kp.key_sync    = 1'b0;
        kp_nr.key_sync = 1'b0;
        test_reset();
        test_glitch();
        test_clean_press();
        test_release_bounce();
        test_auto_repeat();
        test_rpt_suppress();
        test_reset_mid_hold();
        test_repeat_disabled();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
